// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit BCD countdown timer with one-cycle done pulse.
// Define BCD_DOWN_TIMER_AUTO_RELOAD_EN for periodic auto-reload mode.
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  state_t         state;
  logic [W-1:0]   count_q;
  logic [W-1:0]   reload_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   load_c;
  logic [W-1:0]   dec_c;
  logic           load_nz;
  logic           dec_z;
  logic           reload_nz;

  function automatic logic [W-1:0] clamp9(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-value datapath: clamped load value and ripple-borrow decrement.
  always_comb begin
    load_c    = clamp9(load_val);
    dec_c     = bcd_dec(count_q);
    load_nz   = |load_c;
    dec_z     = ~|dec_c;
    reload_nz = |reload_q;
  end

  // Timer FSM with registered count, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        count_q  <= load_c;
        reload_q <= load_c;
        state    <= load_nz ? RUN : IDLE;
        busy_q   <= load_nz;
      end else begin
        unique case (state)
          IDLE: begin
            busy_q <= 1'b0;
          end
          RUN: begin
            if (en) begin
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
              if (~|count_q) begin
                count_q <= reload_q;
                state   <= reload_nz ? RUN : IDLE;
                busy_q  <= reload_nz;
              end else begin
                count_q <= dec_c;
                done_q  <= dec_z;
              end
`else
              count_q <= dec_c;
              if (dec_z) begin
                state  <= EXPIRED;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
`endif
            end
          end
          EXPIRED: begin
            count_q <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign zero  = ~|count_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of load, borrow, clamp, expiry, reset.
// Covers the auto-reload build when BCD_DOWN_TIMER_AUTO_RELOAD_EN is defined.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         done;

  int n_cmp;
  int n_bad;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .zero     (zero),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  task automatic do_load(input logic [W-1:0] v, input logic e);
    load     = 1'b1;
    load_val = v;
    en       = e;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_zero",  32'(zero),  32'h1);
    rst = 1'b0;

`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    // 12 -> 0 countdown then expired hold
    do_load(16'h0012, 1'b1);
    chk("ld12_count", 32'(count), 32'h12);
    chk("ld12_busy",  32'(busy),  32'h1);
    chk("ld12_zero",  32'(zero),  32'h0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("run_count", 32'(count), 32'(to_bcd(12 - k)));
      chk("run_done",  32'(done),  32'(k == 12));
      chk("run_busy",  32'(busy),  32'(k != 12));
    end
    chk("exp_zero", 32'(zero), 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("exp_count", 32'(count), 32'h0);
      chk("exp_done",  32'(done),  32'h0);
      chk("exp_busy",  32'(busy),  32'h0);
    end
`endif

    // full borrow ripple and enable gating
    do_load(16'h1000, 1'b0);
    chk("ld1000", 32'(count), 32'h1000);
    en = 1'b1;
    tick();
    chk("ripple", 32'(count), 32'h0999);
    en = 1'b0; tick();
    chk("en0_a", 32'(count), 32'h0999);
    en = 1'b1; tick();
    chk("en1_b", 32'(count), 32'h0998);
    en = 1'b0; tick();
    chk("en0_c", 32'(count), 32'h0998);
    en = 1'b1; tick();
    chk("en1_d", 32'(count), 32'h0997);
    en = 1'b0;

    // digit clamping and zero load
    do_load(16'h003F, 1'b0);
    chk("clamp_3f", 32'(count), 32'h0039);
    do_load(16'h00A5, 1'b0);
    chk("clamp_a5", 32'(count), 32'h0095);
    do_load(16'hFCB7, 1'b0);
    chk("clamp_all", 32'(count), 32'h9997);
    do_load(16'h0000, 1'b0);
    chk("ld0_count", 32'(count), 32'h0);
    chk("ld0_busy",  32'(busy),  32'h0);
    chk("ld0_done",  32'(done),  32'h0);
    chk("ld0_zero",  32'(zero),  32'h1);
    en = 1'b1; tick();
    chk("idle_hold", 32'(count), 32'h0);
    chk("idle_done", 32'(done),  32'h0);

    // reload mid-run then reset mid-run
    do_load(16'h0005, 1'b1);
    tick();
    tick();
    chk("run2", 32'(count), 32'h0003);
    do_load(16'h0007, 1'b1);
    chk("reld7", 32'(count), 32'h0007);
    tick();
    chk("dec6", 32'(count), 32'h0006);
    rst = 1'b1; tick();
    chk("mrst_count", 32'(count), 32'h0);
    chk("mrst_busy",  32'(busy),  32'h0);
    chk("mrst_done",  32'(done),  32'h0);
    rst = 1'b0; tick();
    chk("post_rst", 32'(count), 32'h0);
    chk("post_busy", 32'(busy), 32'h0);

    // load wins over final decrement
    do_load(16'h0001, 1'b1);
    chk("ld1", 32'(count), 32'h0001);
    do_load(16'h0004, 1'b1);
    chk("race_count", 32'(count), 32'h0004);
    chk("race_done",  32'(done),  32'h0);
    chk("race_busy",  32'(busy),  32'h1);
    en = 1'b0;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    // periodic: 3,2,1,0,3,2,1,0,...
    do_load(16'h0003, 1'b1);
    chk("ar_ld", 32'(count), 32'h3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ar_count", 32'(count), 32'(3 - (k % 4)));
      chk("ar_done",  32'(done),  32'((k % 4) == 3));
      chk("ar_busy",  32'(busy),  32'h1);
    end
    en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
